coilgun_core: RTL and testbench

- Single-stage coilgun fire controller.
- A trigger edge starts an optional programmable delay, then drives the coil-enable output for a bounded on-time.
- The on-time ends on a limit count or on a projectile gate sensor.
- At the end of the shot the block emits a one-cycle hand-off pulse to the next stage; it sits between the trigger/sensor front end and the coil driver.

---
 rtl/coilgun_core.sv | 123 ++++++++++++
 tb/tb_coilgun_core.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/coilgun_core.sv
// Single-stage coilgun fire controller: trigger edge -> optional delay -> bounded
// coil on-time (limit or gate sensor) -> one-cycle hand-off pulse to the next stage.
module coilgun_core #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         I_RST,
  input  logic         I_TRIG,
  input  logic         I_GATE,
  input  logic [W-1:0] I_LMT,
  input  logic [W-1:0] I_DLY,
  input  logic         I_OE,
  input  logic         I_EN,
  input  logic         I_DDS,
  input  logic         I_LDS,
  input  logic         I_LEN,
  output logic         O_SOE,
  output logic         O_EXT,
  output logic         O_RTE,
  output logic [W-1:0] O_ACC
);

  typedef enum logic [1:0] {IDLE, DELAY, FIRE, DONE} state_t;

  state_t         state_q;
  logic           trig_prev_q;
  logic           gate_prev_q;
  logic           ext_q;
  logic           rte_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   dly_q;
  logic [W-1:0]   lmt_q;

  logic           trig_edge;
  logic           gate_edge;
  logic           start;
  logic [W-1:0]   cap;
  logic           lim_hit;

  always_comb begin
    trig_edge = I_TRIG & ~trig_prev_q;
    gate_edge = I_GATE & ~gate_prev_q;
    start     = (state_q == IDLE) & trig_edge & I_EN;
    // A zero limit still yields one FIRE cycle; with the limit disabled the
    // counter's full range is the cap, so ACC can never wrap.
    cap = I_LEN ? lmt_q : '1;
    if (cap == '0) cap = W'(1);
    lim_hit = (acc_q == cap - W'(1));
  end

  // Shot parameters are captured once per shot and not reset.
  always_ff @(posedge clk) begin
    if (!I_RST && start) begin
      dly_q <= I_DLY;
      lmt_q <= I_LMT;
    end
  end

  always_ff @(posedge clk) begin
    if (I_RST) begin
      state_q     <= IDLE;
      trig_prev_q <= 1'b0;
      gate_prev_q <= 1'b0;
      ext_q       <= 1'b0;
      rte_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      trig_prev_q <= I_TRIG;
      gate_prev_q <= I_GATE;
      ext_q       <= 1'b0;
      rte_q       <= 1'b0;
      if (!I_EN) begin
        state_q <= IDLE;
        acc_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            acc_q <= '0;
            if (trig_edge) begin
              state_q <= (I_DDS && (I_DLY != '0)) ? DELAY : FIRE;
            end else begin
              rte_q <= 1'b1;
            end
          end
          DELAY: begin
            if (acc_q == dly_q - W'(1)) begin
              state_q <= FIRE;
              acc_q   <= '0;
            end else begin
              acc_q <= acc_q + W'(1);
            end
          end
          FIRE: begin
            if (lim_hit || (I_LDS && gate_edge)) begin
              state_q <= DONE;
              ext_q   <= 1'b1;
            end else begin
              acc_q <= acc_q + W'(1);
            end
          end
          DONE: begin
            if (!I_TRIG) begin
              state_q <= IDLE;
              acc_q   <= '0;
              rte_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            acc_q   <= '0;
          end
        endcase
      end
    end
  end

  // Coil drive drops in the same cycle that OE or EN falls.
  assign O_SOE = (state_q == FIRE) & I_OE & I_EN;
  assign O_EXT = ext_q;
  assign O_RTE = rte_q;
  assign O_ACC = acc_q;

endmodule

// File: tb/tb_coilgun_core.sv
// Scoreboard bench for coilgun_core: directed shots push per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_coilgun_core;

  localparam int W = 24;

  logic         clk;
  logic         I_RST, I_TRIG, I_GATE, I_OE, I_EN, I_DDS, I_LDS, I_LEN;
  logic [W-1:0] I_LMT, I_DLY;
  logic         O_SOE, O_EXT, O_RTE;
  logic [W-1:0] O_ACC;

  coilgun_core #(.W(W)) dut (
    .clk   (clk),
    .I_RST (I_RST),
    .I_TRIG(I_TRIG),
    .I_GATE(I_GATE),
    .I_LMT (I_LMT),
    .I_DLY (I_DLY),
    .I_OE  (I_OE),
    .I_EN  (I_EN),
    .I_DDS (I_DDS),
    .I_LDS (I_LDS),
    .I_LEN (I_LEN),
    .O_SOE (O_SOE),
    .O_EXT (O_EXT),
    .O_RTE (O_RTE),
    .O_ACC (O_ACC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         soe;
    logic         ext;
    logic         rte;
    logic [W-1:0] acc;
    string        nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Monitor: outputs are presented every cycle; compare away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_chk++;
      if ({O_SOE, O_EXT, O_RTE, O_ACC} !== {mon_e.soe, mon_e.ext, mon_e.rte, mon_e.acc}) begin
        n_fail++;
        $display("FAIL %s: got soe=%0b ext=%0b rte=%0b acc=%0d, expected soe=%0b ext=%0b rte=%0b acc=%0d",
                 mon_e.nm, O_SOE, O_EXT, O_RTE, O_ACC, mon_e.soe, mon_e.ext, mon_e.rte, mon_e.acc);
      end
    end
  end

  // Apply one cycle of inputs and queue the outputs expected during that cycle.
  task automatic cyc(input logic trig, input logic gate, input logic soe, input logic ext,
                     input logic rte, input int acc, input string nm);
    exp_t e;
    I_TRIG = trig;
    I_GATE = gate;
    e.soe = soe;
    e.ext = ext;
    e.rte = rte;
    e.acc = acc[W-1:0];
    e.nm  = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One complete shot from IDLE back to IDLE. Trigger is high for cycles k<thold
  // except k==tgap; the gate rises in FIRE cycle gate_at and stays high.
  task automatic shot(input int ndly, input int nfire, input int gate_at, input logic oe_exp,
                      input int acc_end, input int thold, input int tgap, input string nm);
    int   k;
    logic t, g, first;
    k = 0;
    g = 1'b0;
    cyc(1'b1, g, 1'b0, 1'b0, 1'b1, 0, {nm, "_edge"});
    k++;
    for (int i = 0; i < ndly; i++) begin
      t = (k < thold) && (k != tgap);
      cyc(t, g, 1'b0, 1'b0, 1'b0, i, {nm, "_delay"});
      k++;
    end
    for (int i = 0; i < nfire; i++) begin
      t = (k < thold) && (k != tgap);
      if (i == gate_at) g = 1'b1;
      cyc(t, g, oe_exp, 1'b0, 1'b0, i, {nm, "_fire"});
      k++;
    end
    first = 1'b1;
    do begin
      t = (k < thold) && (k != tgap);
      cyc(t, g, 1'b0, first, 1'b0, acc_end, {nm, "_done"});
      first = 1'b0;
      k++;
    end while (t);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, {nm, "_rearm"});
  endtask

  // Shot with DLY=10 aborted in FIRE cycle 7 by reset or by dropping EN.
  task automatic abort(input logic by_rst, input string nm);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, {nm, "_edge"});
    for (int i = 0; i < 10; i++)
      cyc(i < 2, 1'b0, 1'b0, 1'b0, 1'b0, i, {nm, "_delay"});
    for (int i = 0; i < 7; i++)
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, i, {nm, "_fire"});
    if (by_rst) begin
      I_RST = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7, {nm, "_rst_cycle"});
      I_RST = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, {nm, "_after_rst"});
    end else begin
      I_EN = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, {nm, "_soe_drop"});
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, {nm, "_aborted"});
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, {nm, "_rte_low"});
      I_EN = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, {nm, "_en_back"});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, {nm, "_rearm"});
  endtask

  initial begin
    I_RST = 1'b1; I_TRIG = 1'b0; I_GATE = 1'b0;
    I_OE = 1'b1; I_EN = 1'b1; I_DDS = 1'b1; I_LDS = 1'b1; I_LEN = 1'b1;
    I_DLY = W'(10); I_LMT = W'(20);
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset_state");
    I_RST = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset_release");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, "rte_after_reset");

    shot(10, 20, -1, 1'b1, 19, 3, -1, "nominal");
    shot(10, 6, 5, 1'b1, 5, 3, -1, "gate_cut");
    I_LDS = 1'b0;
    shot(10, 20, 5, 1'b1, 19, 3, -1, "gate_ignored");
    I_LDS = 1'b1;
    I_DDS = 1'b0;
    shot(0, 20, -1, 1'b1, 19, 3, -1, "dds_off");
    I_DDS = 1'b1; I_DLY = W'(0);
    shot(0, 20, -1, 1'b1, 19, 3, -1, "dly_zero");
    I_DLY = W'(10); I_OE = 1'b0;
    shot(10, 20, -1, 1'b0, 19, 3, -1, "oe_off");
    I_OE = 1'b1;
    shot(10, 20, -1, 1'b1, 19, 40, 15, "hold_retrig");
    abort(1'b1, "rst_abort");
    abort(1'b0, "en_abort");
    I_DDS = 1'b0; I_LMT = W'(0);
    shot(0, 1, -1, 1'b1, 0, 3, -1, "lmt_zero");
    I_LMT = W'(5); I_LEN = 1'b0;
    shot(0, 31, 30, 1'b1, 30, 3, -1, "no_limit_gate");
    I_LEN = 1'b1; I_DDS = 1'b1; I_DLY = W'(3); I_LMT = W'(4);
    shot(3, 4, -1, 1'b1, 3, 3, -1, "short_shot");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
